// File: rtl/axi4_burst_cmd_master_if.sv
// rtl/axi4_burst_cmd_master_if.sv - AXI4 write/read channel bundle for the burst command master
interface axi4_burst_cmd_master_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    localparam int STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   AWID_a;
    logic [ADDR_W-1:0] AWADDR_a;
    logic [7:0]        AWLEN_a;
    logic [2:0]        AWSIZE_a;
    logic [1:0]        AWBURST_a;
    logic              AWVALID_a;
    logic              AWREADY_a;

    logic [DATA_W-1:0] WDATA_a;
    logic [STRB_W-1:0] WSTRB_a;
    logic              WLAST_a;
    logic              WVALID_a;
    logic              WREADY_a;

    logic [ID_W-1:0]   BID_a;
    logic [1:0]        BRESP_a;
    logic              BVALID_a;
    logic              BREADY_a;

    logic [ID_W-1:0]   ARID_a;
    logic [ADDR_W-1:0] ARADDR_a;
    logic [7:0]        ARLEN_a;
    logic [2:0]        ARSIZE_a;
    logic [1:0]        ARBURST_a;
    logic              ARVALID_a;
    logic              ARREADY_a;

    logic [ID_W-1:0]   RID_a;
    logic [DATA_W-1:0] RDATA_a;
    logic [1:0]        RRESP_a;
    logic              RLAST_a;
    logic              RVALID_a;
    logic              RREADY_a;

    modport master (
        output AWID_a, AWADDR_a, AWLEN_a, AWSIZE_a, AWBURST_a, AWVALID_a,
        input  AWREADY_a,
        output WDATA_a, WSTRB_a, WLAST_a, WVALID_a,
        input  WREADY_a,
        input  BID_a, BRESP_a, BVALID_a,
        output BREADY_a,
        output ARID_a, ARADDR_a, ARLEN_a, ARSIZE_a, ARBURST_a, ARVALID_a,
        input  ARREADY_a,
        input  RID_a, RDATA_a, RRESP_a, RLAST_a, RVALID_a,
        output RREADY_a
    );

    modport slave (
        input  AWID_a, AWADDR_a, AWLEN_a, AWSIZE_a, AWBURST_a, AWVALID_a,
        output AWREADY_a,
        input  WDATA_a, WSTRB_a, WLAST_a, WVALID_a,
        output WREADY_a,
        output BID_a, BRESP_a, BVALID_a,
        input  BREADY_a,
        input  ARID_a, ARADDR_a, ARLEN_a, ARSIZE_a, ARBURST_a, ARVALID_a,
        output ARREADY_a,
        output RID_a, RDATA_a, RRESP_a, RLAST_a, RVALID_a,
        input  RREADY_a
    );
endinterface

// File: rtl/axi4_burst_cmd_master.sv
// rtl/axi4_burst_cmd_master.sv - FIFO-fed AXI4 master issuing one INCR burst per command word
module axi4_burst_cmd_master #(
    parameter int   DATA_W = 64,
    parameter int   ADDR_W = 32,
    parameter int   ID_W   = 4,
    localparam int  STRB_W = DATA_W / 8,
    localparam int  CMD_W  = 1 + ID_W + 8 + ADDR_W,
    localparam int  RSP_W  = 2 + ID_W + 2 + DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cmd_empty,
    input  logic [CMD_W-1:0]         i_cmd_rdata,
    output logic                     o_cmd_rd_en,
    input  logic                     i_wd_empty,
    input  logic [DATA_W+STRB_W-1:0] i_wd_rdata,
    output logic                     o_wd_rd_en,
    input  logic                     i_rsp_full,
    output logic                     o_rsp_wr_en,
    output logic [RSP_W-1:0]         o_rsp_wdata,
    axi4_burst_cmd_master_if.master  axi,
    output logic                     o_busy,
    output logic                     o_err
);
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_armed;
    logic [ID_W-1:0]   r_id;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    logic w_pop, w_awvalid, w_arvalid, w_wvalid, w_bready, w_rready;
    logic w_cnt_last, w_w_hs, w_b_hs, w_r_hs;

    assign w_cnt_last = (r_cnt == r_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_awvalid = 1'b0;
        w_arvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        w_rready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_armed && !i_cmd_empty) begin
                    w_pop  = 1'b1;
                    w_next = i_cmd_rdata[CMD_W-1] ? S_AW : S_AR;
                end
            end
            S_AW: begin
                w_awvalid = 1'b1;
                if (axi.AWREADY_a) w_next = S_W;
            end
            S_W: begin
                w_wvalid = !i_wd_empty;
                if (w_wvalid && axi.WREADY_a && w_cnt_last) w_next = S_B;
            end
            S_B: begin
                w_bready = !i_rsp_full;
                if (w_bready && axi.BVALID_a) w_next = S_IDLE;
            end
            S_AR: begin
                w_arvalid = 1'b1;
                if (axi.ARREADY_a) w_next = S_R;
            end
            S_R: begin
                w_rready = !i_rsp_full;
                if (w_rready && axi.RVALID_a && axi.RLAST_a) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_w_hs = w_wvalid & axi.WREADY_a;
    assign w_b_hs = w_bready & axi.BVALID_a;
    assign w_r_hs = w_rready & axi.RVALID_a;

    // r_armed keeps the command FIFO untouched while reset is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= 1'b0;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_pop) begin
                r_id   <= i_cmd_rdata[CMD_W-2 -: ID_W];
                r_len  <= i_cmd_rdata[ADDR_W+7:ADDR_W];
                r_addr <= i_cmd_rdata[ADDR_W-1:0];
                r_cnt  <= '0;
            end
            if (w_w_hs || w_r_hs) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_b_hs && (axi.BID_a != r_id)) begin
                r_err <= 1'b1;
            end
            // RLAST must coincide exactly with the len-th beat
            if (w_r_hs && ((axi.RID_a != r_id) || (axi.RLAST_a != w_cnt_last))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_cmd_rd_en = w_pop;
    assign o_wd_rd_en  = w_w_hs;
    assign o_rsp_wr_en = w_b_hs | w_r_hs;
    assign o_rsp_wdata = (r_state == S_B)
                       ? {2'b01, axi.BID_a, axi.BRESP_a, {DATA_W{1'b0}}}
                       : {(axi.RLAST_a ? 2'b11 : 2'b10), axi.RID_a, axi.RRESP_a, axi.RDATA_a};
    assign o_busy      = (r_state != S_IDLE);
    assign o_err       = r_err;

    assign axi.AWID_a    = r_id;
    assign axi.AWADDR_a  = r_addr;
    assign axi.AWLEN_a   = r_len;
    assign axi.AWSIZE_a  = 3'($clog2(STRB_W));
    assign axi.AWBURST_a = 2'b01;
    assign axi.AWVALID_a = w_awvalid;

    assign axi.WDATA_a   = i_wd_rdata[DATA_W-1:0];
    assign axi.WSTRB_a   = i_wd_rdata[DATA_W+STRB_W-1:DATA_W];
    assign axi.WLAST_a   = (r_state == S_W) && w_cnt_last;
    assign axi.WVALID_a  = w_wvalid;

    assign axi.BREADY_a  = w_bready;

    assign axi.ARID_a    = r_id;
    assign axi.ARADDR_a  = r_addr;
    assign axi.ARLEN_a   = r_len;
    assign axi.ARSIZE_a  = 3'($clog2(STRB_W));
    assign axi.ARBURST_a = 2'b01;
    assign axi.ARVALID_a = w_arvalid;

    assign axi.RREADY_a  = w_rready;
endmodule

// File: tb/tb_axi4_burst_cmd_master.sv
// tb/tb_axi4_burst_cmd_master.sv - self-checking bench for axi4_burst_cmd_master
module tb_axi4_burst_cmd_master;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int STRB_W = 8;
    localparam int CMD_W  = 45;
    localparam int RSP_W  = 72;
    localparam int WD_W   = 72;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic              i_cmd_empty;
    logic [CMD_W-1:0]  i_cmd_rdata;
    logic              o_cmd_rd_en;
    logic              i_wd_empty;
    logic [WD_W-1:0]   i_wd_rdata;
    logic              o_wd_rd_en;
    logic              i_rsp_full;
    logic              o_rsp_wr_en;
    logic [RSP_W-1:0]  o_rsp_wdata;
    logic              o_busy;
    logic              o_err;

    axi4_burst_cmd_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) axi ();

    axi4_burst_cmd_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_empty(i_cmd_empty), .i_cmd_rdata(i_cmd_rdata), .o_cmd_rd_en(o_cmd_rd_en),
        .i_wd_empty(i_wd_empty), .i_wd_rdata(i_wd_rdata), .o_wd_rd_en(o_wd_rd_en),
        .i_rsp_full(i_rsp_full), .o_rsp_wr_en(o_rsp_wr_en), .o_rsp_wdata(o_rsp_wdata),
        .axi(axi), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } rbeat_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [CMD_W-1:0] cmd_q[$];
    logic [WD_W-1:0]  wd_q[$];
    logic [WD_W:0]    exp_w[$];
    logic [RSP_W-1:0] exp_rsp[$];
    logic [RSP_W-1:0] obs_rsp[$];
    rbeat_t           r_q[$];

    logic [ID_W-1:0]   exp_id;
    logic [7:0]        exp_len;
    logic [ADDR_W-1:0] exp_addr;
    logic [ID_W-1:0]   b_id;
    logic [1:0]        b_resp;
    logic [ADDR_W-1:0] obs_awaddr;
    logic [7:0]        obs_awlen;
    logic [ID_W-1:0]   obs_awid;
    logic [2:0]        obs_awsize;
    logic [1:0]        obs_awburst;
    logic [ID_W+8+ADDR_W-1:0] prev_aw_fields, prev_ar_fields;

    int aw_delay = 0, aw_cnt = 0, obs_aw_wait = 0;
    int full_after = -1, full_cycles = 0, full_left = 0, full_seen = 0;
    int w_hs_cnt = 0, w_last_cnt = 0, r_acc = 0, cyc = 0, pop_cyc = 0;
    bit wd_toggle = 0, b_pending = 0, r_go = 0, lat_pending = 0;
    bit prev_aw_stall = 0, prev_ar_stall = 0, err_model = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        i_cmd_empty   = (cmd_q.size() == 0);
        i_cmd_rdata   = (cmd_q.size() != 0) ? cmd_q[0] : '0;
        i_wd_empty    = (wd_q.size() == 0) || (wd_toggle && cyc[0]);
        i_wd_rdata    = (wd_q.size() != 0) ? wd_q[0] : '0;
        i_rsp_full    = (full_left > 0);
        axi.AWREADY_a = (aw_cnt >= aw_delay);
        axi.WREADY_a  = 1'b1;
        axi.ARREADY_a = 1'b1;
        axi.BVALID_a  = b_pending;
        axi.BID_a     = b_id;
        axi.BRESP_a   = b_resp;
        axi.RVALID_a  = r_go && (r_q.size() != 0);
        axi.RID_a     = (r_q.size() != 0) ? r_q[0].id   : '0;
        axi.RDATA_a   = (r_q.size() != 0) ? r_q[0].data : '0;
        axi.RRESP_a   = (r_q.size() != 0) ? r_q[0].resp : '0;
        axi.RLAST_a   = (r_q.size() != 0) ? r_q[0].last : 1'b0;
    endtask

    task automatic sample();
        logic [WD_W:0] ew;
        cyc++;
        if (i_rsp_full) begin
            full_seen++;
            full_left--;
            check("rsp_wr_en_while_full", o_rsp_wr_en, 0);
            check("rready_while_full", axi.RREADY_a, 0);
            check("bready_while_full", axi.BREADY_a, 0);
        end
        if (i_wd_empty) check("wvalid_while_wd_empty", axi.WVALID_a, 0);
        check("wd_rd_en", o_wd_rd_en, axi.WVALID_a & axi.WREADY_a);
        if (prev_aw_stall) begin
            check("awvalid_held", axi.AWVALID_a, 1);
            check("aw_fields_stable", {axi.AWID_a, axi.AWLEN_a, axi.AWADDR_a}, prev_aw_fields);
        end
        if (prev_ar_stall) begin
            check("arvalid_held", axi.ARVALID_a, 1);
            check("ar_fields_stable", {axi.ARID_a, axi.ARLEN_a, axi.ARADDR_a}, prev_ar_fields);
        end
        prev_aw_stall  = axi.AWVALID_a && !axi.AWREADY_a;
        prev_aw_fields = {axi.AWID_a, axi.AWLEN_a, axi.AWADDR_a};
        prev_ar_stall  = axi.ARVALID_a && !axi.ARREADY_a;
        prev_ar_fields = {axi.ARID_a, axi.ARLEN_a, axi.ARADDR_a};
        if (lat_pending && (axi.AWVALID_a || axi.ARVALID_a)) begin
            check("cmd_to_axvalid_latency", cyc - pop_cyc, 1);
            lat_pending = 0;
        end
        if (o_cmd_rd_en) begin
            if (cmd_q.size() != 0) void'(cmd_q.pop_front());
            pop_cyc = cyc;
            lat_pending = 1;
        end
        if (axi.AWVALID_a) begin
            if (axi.AWREADY_a) begin
                check("aw_fields", {axi.AWID_a, axi.AWLEN_a, axi.AWADDR_a}, {exp_id, exp_len, exp_addr});
                obs_awaddr = axi.AWADDR_a; obs_awlen = axi.AWLEN_a; obs_awid = axi.AWID_a;
                obs_awsize = axi.AWSIZE_a; obs_awburst = axi.AWBURST_a;
                obs_aw_wait = aw_cnt;
                aw_cnt = 0;
            end else begin
                aw_cnt++;
            end
        end
        if (axi.ARVALID_a && axi.ARREADY_a) begin
            check("ar_fields", {axi.ARID_a, axi.ARLEN_a, axi.ARADDR_a, axi.ARSIZE_a, axi.ARBURST_a},
                  {exp_id, exp_len, exp_addr, 3'd3, 2'b01});
            r_go = 1;
        end
        if (axi.WVALID_a && axi.WREADY_a) begin
            if (exp_w.size() == 0) begin
                check("w_unexpected_beat", 1, 0);
            end else begin
                ew = exp_w.pop_front();
                check("w_beat", {axi.WLAST_a, axi.WSTRB_a, axi.WDATA_a}, ew);
            end
            if (wd_q.size() != 0) void'(wd_q.pop_front());
            w_hs_cnt++;
            if (axi.WLAST_a) begin
                w_last_cnt++;
                b_pending = 1;
            end
        end
        if (axi.BVALID_a && axi.BREADY_a) b_pending = 0;
        if (axi.RVALID_a && axi.RREADY_a) begin
            void'(r_q.pop_front());
            r_acc++;
            if (r_acc == full_after) full_left = full_cycles;
            if (r_q.size() == 0) r_go = 0;
        end
        if (o_rsp_wr_en) begin
            obs_rsp.push_back(o_rsp_wdata);
            if (exp_rsp.size() == 0) check("rsp_unexpected", 1, 0);
            else check("rsp_word", o_rsp_wdata, exp_rsp.pop_front());
        end
    endtask

    initial begin
        drive_inputs();
        forever begin
            @(posedge clk); #1;
            drive_inputs();
            @(negedge clk);
            sample();
        end
    end

    task automatic wait_done();
        bit ok = 0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk); #1;
            ok = (cmd_q.size() == 0) && (exp_rsp.size() == 0) && (exp_w.size() == 0)
                 && (r_q.size() == 0) && !o_busy;
        end
        check("done_before_timeout", ok, 1);
    endtask

    task automatic setup_write(input logic [ID_W-1:0] id, input logic [7:0] len,
                               input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] bid,
                               input logic [1:0] bresp);
        logic [WD_W-1:0] wd;
        for (int k = 0; k <= int'(len); k++) begin
            wd = {8'hFF - 8'(k), 64'hD000_0000_0000_0000 + {addr, 8'(k)}};
            wd_q.push_back(wd);
            exp_w.push_back({(k == int'(len)), wd});
        end
        exp_id = id; exp_len = len; exp_addr = addr;
        b_id = bid; b_resp = bresp;
        exp_rsp.push_back({2'b01, bid, bresp, 64'd0});
        if (bid != id) err_model = 1;
        obs_rsp.delete();
        w_hs_cnt = 0; w_last_cnt = 0;
        cmd_q.push_back({1'b1, id, len, addr});
    endtask

    task automatic run_write(input logic [ID_W-1:0] id, input logic [7:0] len,
                             input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] bid,
                             input logic [1:0] bresp);
        setup_write(id, len, addr, bid, bresp);
        wait_done();
        check("err_vs_model", o_err, err_model);
    endtask

    // Slave returns beats 0..last_at with RLAST on last_at; err follows the beat/RLAST/ID rules
    task automatic run_read(input logic [ID_W-1:0] id, input logic [7:0] len,
                            input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] rid,
                            input int last_at);
        rbeat_t b;
        for (int k = 0; k <= last_at; k++) begin
            b.id = rid; b.data = 64'hA0 + 64'(k); b.resp = 2'b00; b.last = (k == last_at);
            r_q.push_back(b);
            exp_rsp.push_back({(b.last ? 2'b11 : 2'b10), rid, 2'b00, b.data});
            if ((b.last && k != int'(len)) || (!b.last && k == int'(len)) || rid != id) err_model = 1;
        end
        exp_id = id; exp_len = len; exp_addr = addr;
        r_acc = 0;
        obs_rsp.delete();
        cmd_q.push_back({1'b0, id, len, addr});
        wait_done();
        check("err_vs_model", o_err, err_model);
    endtask

    task automatic check_reset(input string name);
        check(name, {axi.AWVALID_a, axi.WVALID_a, axi.WLAST_a, axi.BREADY_a, axi.ARVALID_a,
                     axi.RREADY_a, o_cmd_rd_en, o_wd_rd_en, o_rsp_wr_en, o_busy, o_err}, 0);
        check({name, "_fields"}, {axi.AWADDR_a, axi.AWID_a, axi.AWLEN_a,
                                  axi.ARADDR_a, axi.ARID_a, axi.ARLEN_a}, 0);
    endtask

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #2;
        check_reset("reset_state");
        rst = 1'b0;

        // single-beat write, AWREADY after 2 cycles
        aw_delay = 2;
        run_write(4'd3, 8'd0, 32'h1000, 4'd3, 2'b00);
        check("t1_rsp_count", obs_rsp.size(), 1);
        if (obs_rsp.size() != 0) check("t1_rsp_word", obs_rsp[0], {2'b01, 4'd3, 2'b00, 64'd0});
        check("t1_awaddr", obs_awaddr, 32'h1000);
        check("t1_awlen_id", {obs_awlen, obs_awid}, {8'd0, 4'd3});
        check("t1_awsize_burst", {obs_awsize, obs_awburst}, {3'd3, 2'b01});
        check("t1_aw_wait", obs_aw_wait, 2);
        check("t1_w_beats", {w_hs_cnt[7:0], w_last_cnt[7:0]}, {8'd1, 8'd1});
        check("t1_err", o_err, 0);
        aw_delay = 0;

        // 8-beat write with wd_empty toggling
        wd_toggle = 1;
        run_write(4'd6, 8'd7, 32'h2000, 4'd6, 2'b00);
        check("t2_w_beats", w_hs_cnt, 8);
        check("t2_wlast_count", w_last_cnt, 1);
        wd_toggle = 0;

        // 4-beat read
        run_read(4'd5, 8'd3, 32'h3000, 4'd5, 3);
        check("t3_rsp_count", obs_rsp.size(), 4);
        for (int k = 0; k < 4 && k < obs_rsp.size(); k++)
            check("t3_rsp_literal", obs_rsp[k], {((k == 3) ? 2'b11 : 2'b10), 4'd5, 2'b00, 64'hA0 + 64'(k)});

        // 4-beat read with response FIFO full for 5 cycles after beat 2
        full_after = 2; full_cycles = 5; full_seen = 0;
        run_read(4'd5, 8'd3, 32'h3100, 4'd5, 3);
        check("t4_full_cycles", full_seen, 5);
        check("t4_rsp_count", obs_rsp.size(), 4);
        full_after = -1;

        // early RLAST on the third beat
        run_read(4'd2, 8'd3, 32'h4000, 4'd2, 2);
        check("t5_err_set", o_err, 1);
        check("t5_idle", o_busy, 0);
        check("t5_rsp_count", obs_rsp.size(), 3);
        if (obs_rsp.size() == 3) check("t5_last_kind", obs_rsp[2][RSP_W-1:RSP_W-2], 2'b11);
        run_read(4'd2, 8'd1, 32'h4100, 4'd2, 1);
        check("t5_err_sticky", o_err, 1);

        // reset during the third W beat of an 8-beat write
        setup_write(4'd7, 8'd7, 32'h5000, 4'd7, 2'b00);
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(posedge clk); #2;
            ok = (w_hs_cnt >= 2);
        end
        check("t6_reached_beat3", ok, 1);
        check("t6_mid_burst", {o_busy, axi.WVALID_a}, 2'b11);
        rst = 1'b1;
        #1;
        check_reset("t6_reset_mid_burst");
        cmd_q.delete(); wd_q.delete(); exp_w.delete(); exp_rsp.delete(); r_q.delete();
        b_pending = 0; r_go = 0; aw_cnt = 0; lat_pending = 0; err_model = 0;
        prev_aw_stall = 0; prev_ar_stall = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        run_write(4'd9, 8'd1, 32'h5100, 4'd9, 2'b10);
        check("t6_after_reset_err", o_err, 0);
        check("t6_after_reset_beats", w_hs_cnt, 2);
        if (obs_rsp.size() != 0) check("t6_after_reset_rsp", obs_rsp[0], {2'b01, 4'd9, 2'b10, 64'd0});

        // BID mismatch sets err
        run_write(4'd4, 8'd0, 32'h6000, 4'd5, 2'b00);
        check("t7_bid_mismatch_err", o_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
